// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer
//
// Sits between hps_io and the game core. Forwards HPS ROM download bytes onto
// a registered dn_* write bus and tags each byte with one of four ROM regions.
// It counts accepted bytes and keeps the core in reset until a complete image
// has arrived. Once loaded, reset is held for RESET_HOLD more cycles and then
// released. A user reset request while running re-enters the hold period.
//
// Optional feature (macro DL_CHECKSUM_EN):
//   defined   - dl_sum accumulates the accepted bytes (mod 2^16), and a sum
//               that differs from EXP_SUM at download end is an error.
//   undefined - no summing logic; dl_sum is constant zero.
//
// Ports:
//   clk_sys        in   system clock
//   reset_n        in   asynchronous active-low reset
//   ioctl_download in   HPS download in progress
//   ioctl_wr       in   byte strobe, one cycle per byte
//   ioctl_addr     in   [24:0] byte address of ioctl_dout
//   ioctl_dout     in   [7:0] download byte
//   user_reset     in   OSD/button reset request (level)
//   dn_addr        out  [AW-1:0] registered write address to the core
//   dn_data        out  [7:0] registered write data to the core
//   dn_wr          out  one-cycle write strobe to the core
//   dn_region      out  [1:0] region index of the current dn_wr byte
//   core_reset     out  active-high core reset
//   load_done      out  a complete image is resident
//   load_err       out  last download short, oversize or bad checksum
//   dl_sum         out  [15:0] running checksum (zero without DL_CHECKSUM_EN)

module rom_load_sequencer #(
  parameter int          AW         = 17,
  parameter int          ROM_SIZE   = 65536,
  parameter int          REG1_BASE  = 'h4000,
  parameter int          REG2_BASE  = 'h8000,
  parameter int          REG3_BASE  = 'hC000,
  parameter int          RESET_HOLD = 16,
  parameter logic [15:0] EXP_SUM    = 16'h0000
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic          user_reset,
  output logic [AW-1:0] dn_addr,
  output logic [7:0]    dn_data,
  output logic          dn_wr,
  output logic [1:0]    dn_region,
  output logic          core_reset,
  output logic          load_done,
  output logic          load_err,
  output logic [15:0]   dl_sum
);

  localparam int              HW        = $clog2(RESET_HOLD + 1);
  localparam logic [HW-1:0]   HOLD_LOAD = HW'(RESET_HOLD);
  localparam logic [24:0]     ROM_END   = 25'(ROM_SIZE);
  localparam logic [74:0]     REG_BASES = {25'(REG3_BASE), 25'(REG2_BASE), 25'(REG1_BASE)};

  typedef enum logic [2:0] {
    S_INIT,
    S_LOAD,
    S_HOLD,
    S_RUN,
    S_ERR
  } state_t;

  state_t        state_reg;
  state_t        state_next;

  logic          dl_reg;
  logic [24:0]   count_reg;
  logic          ovf_reg;
  logic [HW-1:0] hold_reg;
  logic          core_reset_reg;
  logic          load_done_reg;
  logic          load_err_reg;
  logic [AW-1:0] dn_addr_reg;
  logic [7:0]    dn_data_reg;
  logic          dn_wr_reg;
  logic [1:0]    dn_region_reg;

  logic          dl_rise;
  logic          dl_fall;
  logic          in_load;
  logic          addr_ok;
  logic          accept;
  logic          reject;
  logic          sum_ok;
  logic          image_ok;
  logic [2:0]    at_or_above;
  logic [1:0]    region;

  // Edges are taken against the registered copy so that the rise cycle itself
  // already behaves as LOAD and can accept the first byte.
  assign dl_rise  = ioctl_download & ~dl_reg;
  assign dl_fall  = ~ioctl_download & dl_reg;
  assign in_load  = dl_rise | (state_reg == S_LOAD);
  assign addr_ok  = (ioctl_addr < ROM_END);
  assign accept   = ioctl_wr & in_load & addr_ok;
  assign reject   = ioctl_wr & in_load & ~addr_ok;
  assign image_ok = (count_reg == ROM_END) & ~ovf_reg & sum_ok;

  // Bases are strictly increasing, so the comparisons form a thermometer code
  // and the region index is simply the number of bases at or below the address.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_region
      assign at_or_above[gi] = (ioctl_addr >= REG_BASES[gi*25 +: 25]);
    end
  endgenerate

  assign region = {1'b0, at_or_above[0]} + {1'b0, at_or_above[1]} + {1'b0, at_or_above[2]};

  // State register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. A download rise overrides everything else.
  always_comb begin
    state_next = state_reg;
    if (dl_rise) begin
      state_next = S_LOAD;
    end else begin
      case (state_reg)
        S_LOAD:  if (dl_fall) state_next = image_ok ? S_HOLD : S_ERR;
        S_HOLD:  if (!user_reset && (hold_reg == '0)) state_next = S_RUN;
        S_RUN:   if (user_reset) state_next = S_HOLD;
        default: state_next = state_reg;
      endcase
    end
  end

  // Download edge detector, byte accounting and status flags
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_reg         <= 1'b0;
      count_reg      <= '0;
      ovf_reg        <= 1'b0;
      hold_reg       <= '0;
      core_reset_reg <= 1'b1;
      load_done_reg  <= 1'b0;
      load_err_reg   <= 1'b0;
    end else begin
      dl_reg <= ioctl_download;

      if (dl_rise) begin
        count_reg <= accept ? 25'd1 : 25'd0;
        ovf_reg   <= reject;
      end else begin
        if (accept && (count_reg != '1)) count_reg <= count_reg + 25'd1;
        if (reject) ovf_reg <= 1'b1;
      end

      // Reload on entry and on every cycle the user still holds reset, so the
      // hold period is always measured from the last reset request.
      if ((state_next == S_HOLD) && ((state_reg != S_HOLD) || user_reset)) begin
        hold_reg <= HOLD_LOAD;
      end else if ((state_reg == S_HOLD) && (hold_reg != '0)) begin
        hold_reg <= hold_reg - HW'(1);
      end

      core_reset_reg <= (state_next != S_RUN);

      if (dl_rise) begin
        load_done_reg <= 1'b0;
      end else if ((state_reg == S_HOLD) && (state_next == S_RUN)) begin
        load_done_reg <= 1'b1;
      end

      if (dl_rise) begin
        load_err_reg <= 1'b0;
      end else if ((state_reg == S_LOAD) && (state_next == S_ERR)) begin
        load_err_reg <= 1'b1;
      end
    end
  end

  // Registered write bus toward the core; address/data/region hold between strobes
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dn_addr_reg   <= '0;
      dn_data_reg   <= '0;
      dn_wr_reg     <= 1'b0;
      dn_region_reg <= '0;
    end else begin
      dn_wr_reg <= accept;
      if (accept) begin
        dn_addr_reg   <= ioctl_addr[AW-1:0];
        dn_data_reg   <= ioctl_dout;
        dn_region_reg <= region;
      end
    end
  end

`ifdef DL_CHECKSUM_EN
  logic [15:0] sum_reg;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sum_reg <= '0;
    end else if (dl_rise) begin
      sum_reg <= accept ? {8'h00, ioctl_dout} : 16'h0000;
    end else if (accept) begin
      sum_reg <= sum_reg + {8'h00, ioctl_dout};
    end
  end

  assign sum_ok = (sum_reg == EXP_SUM);
  assign dl_sum = sum_reg;
`else
  // No summing: every image passes the checksum test and dl_sum reads zero.
  assign sum_ok = 1'b1;
  assign dl_sum = EXP_SUM & 16'h0000;
`endif

  assign dn_addr    = dn_addr_reg;
  assign dn_data    = dn_data_reg;
  assign dn_wr      = dn_wr_reg;
  assign dn_region  = dn_region_reg;
  assign core_reset = core_reset_reg;
  assign load_done  = load_done_reg;
  assign load_err   = load_err_reg;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Testbench for rom_load_sequencer. The image is scaled down (4 KiB, regions
// every 1 KiB) so that several complete downloads fit in a short run.
module tb_rom_load_sequencer;

  localparam int          AW         = 12;
  localparam int          ROM_SIZE   = 4096;
  localparam int          REG1_BASE  = 'h400;
  localparam int          REG2_BASE  = 'h800;
  localparam int          REG3_BASE  = 'hC00;
  localparam int          RESET_HOLD = 16;
  // Sum of (addr & 0xFF) over a 4096-byte image, i.e. the T1 pattern image.
  localparam logic [15:0] EXP_SUM    = 16'hF800;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          ioctl_download;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          user_reset;
  logic [AW-1:0] dn_addr;
  logic [7:0]    dn_data;
  logic          dn_wr;
  logic [1:0]    dn_region;
  logic          core_reset;
  logic          load_done;
  logic          load_err;
  logic [15:0]   dl_sum;

  rom_load_sequencer #(
    .AW(AW), .ROM_SIZE(ROM_SIZE), .REG1_BASE(REG1_BASE), .REG2_BASE(REG2_BASE),
    .REG3_BASE(REG3_BASE), .RESET_HOLD(RESET_HOLD), .EXP_SUM(EXP_SUM)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .user_reset(user_reset), .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr),
    .dn_region(dn_region), .core_reset(core_reset), .load_done(load_done),
    .load_err(load_err), .dl_sum(dl_sum)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;

  // Reference model: what the write bus should be holding and what the
  // current download has accumulated.
  logic [AW-1:0] last_addr   = '0;
  logic [7:0]    last_data   = '0;
  logic [1:0]    last_region = '0;
  int            m_cnt;
  bit            m_ovf;
  logic [15:0]   m_sum;

  typedef struct {
    logic [24:0]   addr;
    logic [7:0]    data;
    logic          wr_o;
    logic [AW-1:0] addr_o;
    logic [7:0]    data_o;
    logic [1:0]    reg_o;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Region = number of region bases at or below the address.
  function automatic logic [1:0] region_of(input int unsigned a);
    int unsigned bases[3];
    int n;
    bases = '{REG1_BASE, REG2_BASE, REG3_BASE};
    n = 0;
    for (int k = 0; k < 3; k++) if (a >= bases[k]) n++;
    return 2'(n);
  endfunction

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    bit acc;
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
    acc = (int'(a) < ROM_SIZE);
    if (acc) begin
      m_cnt++;
      m_sum       = m_sum + 16'(d);
      last_addr   = a[AW-1:0];
      last_data   = d;
      last_region = region_of(32'(a));
    end else begin
      m_ovf = 1'b1;
    end
    check("dn_wr", dn_wr, acc);
    check("dn_addr", dn_addr, last_addr);
    check("dn_data", dn_data, last_data);
    check("dn_region", dn_region, last_region);
  endtask

  task automatic idle();
    ioctl_wr = 1'b0;
    tick();
    check("idle_dn_wr", dn_wr, 0);
  endtask

  task automatic download(input string tag, input int nbytes, input int bad_pos,
                          input logic [24:0] bad_addr, input bit pattern,
                          input bit gaps, input bit wr_on_rise);
    int          n;
    bit          ok;
    bit          first;
    logic [15:0] exp_sum;
    m_cnt = 0;
    m_ovf = 1'b0;
    m_sum = '0;
    user_reset = 1'b0;
    ioctl_download = 1'b1;
    first = wr_on_rise;
    if (!wr_on_rise) begin
      tick();
      check("rise_core_reset", core_reset, 1);
      check("rise_load_done", load_done, 0);
      check("rise_load_err", load_err, 0);
      check("rise_dn_wr", dn_wr, 0);
    end
    for (int i = 0; i <= nbytes; i++) begin
      if (i == bad_pos) send_byte(bad_addr, 8'($urandom));
      if (i == nbytes) break;
      if (gaps && i > 0 && $urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) idle();
      send_byte(25'(i), pattern ? 8'(i) : 8'($urandom));
      if (first) begin
        first = 1'b0;
        check("rise_wr_core_reset", core_reset, 1);
        check("rise_wr_load_done", load_done, 0);
        check("rise_wr_load_err", load_err, 0);
      end
    end
    check("load_core_reset", core_reset, 1);
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    tick();
`ifdef DL_CHECKSUM_EN
    exp_sum = m_sum;
    ok = (m_cnt == ROM_SIZE) && !m_ovf && (m_sum == EXP_SUM);
`else
    exp_sum = 16'h0000;
    ok = (m_cnt == ROM_SIZE) && !m_ovf;
`endif
    check("fall_dl_sum", dl_sum, exp_sum);
    check("fall_load_err", load_err, !ok);
    check("fall_core_reset", core_reset, 1);
    check("fall_load_done", load_done, 0);
    if (ok) begin
      n = 0;
      while (core_reset && n < 4 * RESET_HOLD + 8) begin
        tick();
        n++;
      end
      check("release_delay", n, RESET_HOLD + 1);
      check("run_load_done", load_done, 1);
    end else begin
      for (int i = 0; i < 3 * RESET_HOLD; i++) begin
        user_reset = 1'($urandom_range(0, 1));
        tick();
      end
      user_reset = 1'b0;
      tick();
      check("err_core_reset", core_reset, 1);
      check("err_load_done", load_done, 0);
      check("err_load_err", load_err, 1);
    end
    $display("download %s: bytes=%0d accepted=%0d overflow=%0d sum=%04h image_ok=%0d",
             tag, nbytes, m_cnt, m_ovf, m_sum, ok);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{25'h0003FF, 8'h11, 1'b1, 12'h3FF, 8'h11, 2'd0};
    vecs[1] = '{25'h000400, 8'h22, 1'b1, 12'h400, 8'h22, 2'd1};
    vecs[2] = '{25'h0007FF, 8'h33, 1'b1, 12'h7FF, 8'h33, 2'd1};
    vecs[3] = '{25'h000800, 8'h44, 1'b1, 12'h800, 8'h44, 2'd2};
    vecs[4] = '{25'h000C00, 8'h55, 1'b1, 12'hC00, 8'h55, 2'd3};
    vecs[5] = '{25'h001000, 8'h66, 1'b0, 12'hC00, 8'h55, 2'd3};
    vecs[6] = '{25'h000FFF, 8'h77, 1'b1, 12'hFFF, 8'h77, 2'd3};
    vecs[7] = '{25'h1234567, 8'h88, 1'b0, 12'hFFF, 8'h77, 2'd3};
    vecs[8] = '{25'h000000, 8'h99, 1'b1, 12'h000, 8'h99, 2'd0};
    vecs[9] = '{25'h000BFF, 8'hAA, 1'b1, 12'hBFF, 8'hAA, 2'd2};

    // Reset state
    reset_n = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    user_reset = 1'b0;
    #1 reset_n = 1'b0;
    #3;
    check("rst_dn_addr", dn_addr, 0);
    check("rst_dn_data", dn_data, 0);
    check("rst_dn_wr", dn_wr, 0);
    check("rst_dn_region", dn_region, 0);
    check("rst_core_reset", core_reset, 1);
    check("rst_load_done", load_done, 0);
    check("rst_load_err", load_err, 0);
    check("rst_dl_sum", dl_sum, 0);
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys) reset_n = 1'b1;
    tick();

    // INIT ignores user_reset and stray writes
    user_reset = 1'b1;
    ioctl_wr = 1'b1;
    ioctl_addr = 25'h10;
    repeat (RESET_HOLD + 4) tick();
    user_reset = 1'b0;
    ioctl_wr = 1'b0;
    check("init_core_reset", core_reset, 1);
    check("init_load_done", load_done, 0);
    check("init_dn_wr", dn_wr, 0);
    $display("init: user_reset and ioctl_wr ignored");

    // T2: region boundaries and rejected oversize bytes, table-driven
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      ioctl_wr = 1'b1;
      ioctl_addr = vecs[i].addr;
      ioctl_dout = vecs[i].data;
      tick();
      ioctl_wr = 1'b0;
      check("vec_dn_wr", dn_wr, vecs[i].wr_o);
      check("vec_dn_addr", dn_addr, vecs[i].addr_o);
      check("vec_dn_data", dn_data, vecs[i].data_o);
      check("vec_dn_region", dn_region, vecs[i].reg_o);
      $display("vec %0d: addr=%07h wr=%0d dn_addr=%03h dn_data=%02h region=%0d",
               i, vecs[i].addr, dn_wr, dn_addr, dn_data, dn_region);
    end
    last_addr = vecs[9].addr_o;
    last_data = vecs[9].data_o;
    last_region = vecs[9].reg_o;
    ioctl_download = 1'b0;
    tick();
    tick();
    check("vec_load_err", load_err, 1);
    check("vec_core_reset", core_reset, 1);
    $display("table download: short with oversize bytes -> error");

    // T1: complete image, back-to-back bytes
    download("T1_full", ROM_SIZE, -1, 25'h0, 1'b1, 1'b0, 1'b0);

    // T5: user reset pulse of 5 cycles in RUN
    user_reset = 1'b1;
    tick();
    check("ur_core_reset", core_reset, 1);
    check("ur_load_done", load_done, 1);
    repeat (4) begin
      tick();
      check("ur_hold_core_reset", core_reset, 1);
    end
    user_reset = 1'b0;
    n = 0;
    while (core_reset && n < 100) begin
      tick();
      n++;
      check("ur_load_done_hold", load_done, 1);
    end
    check("ur_release_delay", n, RESET_HOLD + 1);
    $display("user reset: released %0d cycles after last request cycle", n);

    // Writes outside LOAD are ignored
    ioctl_wr = 1'b1;
    ioctl_addr = 25'h123;
    tick();
    ioctl_wr = 1'b0;
    check("run_wr_ignored", dn_wr, 0);
    $display("run: stray ioctl_wr ignored, dn_wr=%0d", dn_wr);

    // T6: download rise in RUN with the first byte in the same cycle
    download("T6_rise_in_run", ROM_SIZE, -1, 25'h0, 1'b0, 1'b1, 1'b1);
    // T3: one byte short
    download("T3_short", ROM_SIZE - 1, -1, 25'h0, 1'b0, 1'b0, 1'b0);
    // T4: complete image plus one byte just past the end
    download("T4_oversize", ROM_SIZE, ROM_SIZE, 25'(ROM_SIZE), 1'b0, 1'b0, 1'b0);

    // Randomised downloads
    for (int r = 0; r < 3; r++) begin
      case ($urandom_range(0, 2))
        0: download("rand_full", ROM_SIZE, -1, 25'h0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
        1: download("rand_short", int'($urandom_range(1, ROM_SIZE - 1)), -1, 25'h0, 1'b0,
                    1'b1, 1'($urandom_range(0, 1)));
        default: download("rand_oversize", ROM_SIZE, int'($urandom_range(0, ROM_SIZE)),
                          25'(ROM_SIZE) + 25'($urandom_range(0, 'hFFFFF)), 1'b0, 1'b1,
                          1'($urandom_range(0, 1)));
      endcase
    end

    // Reset in the middle of a download
    m_cnt = 0;
    m_ovf = 1'b0;
    m_sum = '0;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) send_byte(25'(i), 8'($urandom));
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    #2;
    check("mid_rst_dn_addr", dn_addr, 0);
    check("mid_rst_dn_wr", dn_wr, 0);
    check("mid_rst_core_reset", core_reset, 1);
    check("mid_rst_load_done", load_done, 0);
    check("mid_rst_dl_sum", dl_sum, 0);
    @(negedge clk_sys) reset_n = 1'b1;
    user_reset = 1'b1;
    repeat (RESET_HOLD + 4) tick();
    user_reset = 1'b0;
    tick();
    check("mid_rst_init_core_reset", core_reset, 1);
    check("mid_rst_init_load_err", load_err, 0);
    check("mid_rst_init_load_done", load_done, 0);
    $display("reset mid-download: back in INIT, core held in reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
